// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl : run/halt/step sequencer and hazard control for the
// 5-stage pipeline. Optional statistics counters: define HAZ_STATS_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Run_Req,
  input  logic             Step_Req,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic [4:0]       EX_Rt,
  input  logic             EX_MemRead,
  input  logic             Br_Taken_EX,
  input  logic             Jump_ID,
  input  logic             Mem_Busy,
  output logic             PC_En,
  output logic             IF_ID_En,
  output logic             IF_ID_Flush,
  output logic             ID_EX_En,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_En,
  output logic             MEM_WB_En,
  output logic [1:0]       State,
  output logic             Fault,
  output logic [CNT_W-1:0] Stall_Count,
  output logic [CNT_W-1:0] Flush_Count
);

  typedef enum logic [1:0] {
    S_HALT    = 2'd0,
    S_RUN     = 2'd1,
    S_STEP    = 2'd2,
    S_MEMWAIT = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     cur_state;
  logic [7:0] wait_cnt;
  logic       fault_flag;

  logic advance;
  logic go;
  logic load_use;
  logic branch_evt;
  logic stall_lu;
  logic jump_evt;

  assign advance    = (cur_state == S_RUN) || (cur_state == S_STEP);
  assign go         = advance && !Mem_Busy;
  assign load_use   = EX_MemRead && (EX_Rt != 5'd0) &&
                      ((EX_Rt == ID_Rs) || (EX_Rt == ID_Rt));
  assign branch_evt = go && Br_Taken_EX;
  assign stall_lu   = go && !Br_Taken_EX && load_use;
  assign jump_evt   = go && !Br_Taken_EX && !load_use && Jump_ID;

  // ID/EX stays enabled on a load-use stall so the bubble is captured.
  assign PC_En       = go && !stall_lu;
  assign IF_ID_En    = go && !stall_lu;
  assign IF_ID_Flush = branch_evt || jump_evt;
  assign ID_EX_En    = go;
  assign ID_EX_Flush = branch_evt || stall_lu;
  assign EX_MEM_En   = go;
  assign MEM_WB_En   = go;

  assign State = cur_state;
  assign Fault = fault_flag;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cur_state  <= S_HALT;
      wait_cnt   <= 8'd0;
      fault_flag <= 1'b0;
    end else begin
      case (cur_state)
        S_HALT: begin
          if (Run_Req && !fault_flag)       cur_state <= S_RUN;
          else if (Step_Req && !fault_flag) cur_state <= S_STEP;
        end
        S_STEP: begin
          if (Mem_Busy) begin
            cur_state <= S_MEMWAIT;
            wait_cnt  <= 8'd0;
          end else begin
            cur_state <= S_HALT;
          end
        end
        S_RUN: begin
          if (Mem_Busy) begin
            cur_state <= S_MEMWAIT;
            wait_cnt  <= 8'd0;
          end else if (!Run_Req) begin
            cur_state <= S_HALT;
          end
        end
        S_MEMWAIT: begin
          if (!Mem_Busy) begin
            cur_state <= Run_Req ? S_RUN : S_HALT;
          end else if (wait_cnt >= TIMEOUT_LAST) begin
            fault_flag <= 1'b1;
            cur_state  <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: cur_state <= S_HALT;
      endcase
    end
  end

`ifdef HAZ_STATS_EN
  logic             stall_evt;
  logic             flush_evt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Memory-wait stalls are counted for every cycle busy is seen while live.
  assign stall_evt = stall_lu || (Mem_Busy && (advance || (cur_state == S_MEMWAIT)));
  assign flush_evt = branch_evt || jump_evt;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_evt && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_evt && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign Stall_Count = stall_cnt;
  assign Flush_Count = flush_cnt;
`else
  assign Stall_Count = '0;
  assign Flush_Count = '0;
`endif

endmodule

`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central sequencer for the 5-stage pipeline (IF/ID/EX/MEM/WB).
- Generates the PC enable, plus per-pipeline-register enable and flush.
- Detects load-use hazards, branch/jump redirects and memory wait.
- Runs a run/halt/single-step FSM so the board can step the CPU under the slow divided clock.
- Sits in the CPU top, clocked by the divided clock; its enables/flushes feed the stage blocks.

Parameters:
MEM_TIMEOUT, 15, maximum consecutive Mem_Busy cycles before a fault halt (1..255)
CNT_W, 16, width of the stall and flush statistics counters

Ports:
Clk  input  1  pipeline clock (divided clock)
Rst  input  1  asynchronous, active-low reset
Run_Req  input  1  level; 1 = free-run, 0 = halt
Step_Req  input  1  single-cycle pulse; advance one cycle while halted
ID_Rs  input  5  rs field of instruction in ID
ID_Rt  input  5  rt field of instruction in ID
EX_Rt  input  5  destination rt of instruction in EX
EX_MemRead  input  1  instruction in EX is a load
Br_Taken_EX  input  1  branch resolved taken in EX
Jump_ID  input  1  jump decoded in ID
Mem_Busy  input  1  data memory not ready this cycle
PC_En  output  1  PC register write enable
IF_ID_En  output  1  IF/ID register enable
IF_ID_Flush  output  1  IF/ID synchronous clear to NOP
ID_EX_En  output  1  ID/EX register enable
ID_EX_Flush  output  1  ID/EX synchronous clear to NOP (bubble)
EX_MEM_En  output  1  EX/MEM register enable
MEM_WB_En  output  1  MEM/WB register enable
State  output  2  FSM state: 0 HALT, 1 RUN, 2 STEP, 3 MEMWAIT
Fault  output  1  sticky memory-timeout flag
Stall_Count  output  CNT_W  load-use plus memory-wait stall cycles
Flush_Count  output  CNT_W  flush events

Behaviour:
Reset (Rst=0, async):
- State=HALT, Fault=0, counters=0.
- All enables=0, all flushes=0.
- Reset mid-operation aborts any state immediately.

Advance gating:
- advance = (State==RUN) or (State==STEP).
- All enables and flushes are combinational from current state and inputs, gated by advance.
- In HALT and MEMWAIT, all flushes are 0.

FSM, evaluated on the rising Clk edge:
- HALT: Run_Req=1 and Fault=0 -> RUN; else Step_Req=1 and Fault=0 -> STEP; else stay.
- STEP: lasts exactly one cycle. Mem_Busy=1 -> MEMWAIT; else -> HALT.
- RUN: Mem_Busy=1 -> MEMWAIT; else Run_Req=0 -> HALT; else stay.
- MEMWAIT: all enables=0; wait counter increments each cycle.
  - Mem_Busy=0 -> RUN if Run_Req=1, else HALT.
  - Counter reaches MEM_TIMEOUT with Mem_Busy still 1 -> Fault=1, go to HALT.
  - Fault clears only on reset.
- Wait counter clears on MEMWAIT entry.
- Mem_Busy in RUN/STEP also forces all enables to 0 that same cycle (the pipeline freezes on the cycle busy is first seen).

Hazard priority when advancing and Mem_Busy=0 (highest first):
1. Br_Taken_EX=1:
   - IF_ID_Flush=1, ID_EX_Flush=1; all enables=1.
   - Flush_Count +1.
   - Any load-use or jump condition that cycle is ignored.
2. Load-use (EX_MemRead=1, EX_Rt!=0, and EX_Rt==ID_Rs or EX_Rt==ID_Rt):
   - PC_En=0, IF_ID_En=0, ID_EX_Flush=1; EX_MEM_En=MEM_WB_En=1.
   - Stall_Count +1.
   - Exactly one bubble per load-use pair: the next cycle's EX holds the bubble, so the condition clears.
3. Jump_ID=1:
   - IF_ID_Flush=1; all enables=1.
   - Flush_Count +1.
4. No hazard: all enables=1, flushes=0.

Additional rules:
- Stall_Count also increments on every MEMWAIT cycle and on the busy cycle in RUN/STEP.
- Counters saturate at all-ones; they never wrap.
- Register 0 never causes a hazard.

Optional Feature:
Macro HAZ_STATS_EN.
- Defined: Stall_Count and Flush_Count are implemented as above.
- Undefined: no counter registers are built; both outputs are tied to 0. FSM and control behaviour are identical.

Test Plan:
- Reset, then release with Run_Req=1 -> State=HALT at release; one Clk later State=RUN, all enables=1, flushes=0.
- RUN; EX_MemRead=1, EX_Rt=5, ID_Rs=5 for one cycle -> that cycle PC_En=0, IF_ID_En=0, ID_EX_Flush=1; Stall_Count 0->1. Same stimulus with EX_Rt=0 -> no stall.
- RUN; Br_Taken_EX=1 together with a load-use match and Jump_ID=1 -> IF_ID_Flush=1, ID_EX_Flush=1, PC_En=1; Flush_Count +1; Stall_Count unchanged.
- Run_Req=0 in HALT; pulse Step_Req -> State HALT->STEP->HALT; enables=1 for exactly one cycle.
- RUN; Mem_Busy=1 for 4 cycles -> State=MEMWAIT, enables=0 throughout; returns to RUN; Stall_Count +4.
- MEM_TIMEOUT=15, Mem_Busy held high -> Fault=1 and State=HALT after 15 MEMWAIT cycles; Run_Req=1 is ignored until Rst is pulsed low.
